// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait/timeout > exception > branch > load-use.
// Outputs are combinational from state and inputs; optional HAZARD_PERF_CNT_EN adds perf counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs_addr_i,
  input  logic [4:0] id_rt_addr_i,
  input  logic       id_uses_rs_i,
  input  logic       id_uses_rt_i,
  input  logic       ex_regwr_i,
  input  logic       ex_memtoreg_i,
  input  logic [4:0] ex_regdst_addr_i,
  input  logic       ex_br_taken_i,
  input  logic       mem_dmen_i,
  input  logic       dmem_ready_i,
  input  logic       mem_exc_req_i,
  output logic       pc_stall_o,
  output logic       ifid_stall_o,
  output logic       pa_idexmemwr_o,
  output logic       wash_ifid_o,
  output logic       wash_idex_o,
  output logic       wash_exmem_o,
  output logic       exc_redirect_o,
  output logic       bus_err_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  input  logic        perf_clr_i,
  output logic [31:0] perf_memwait_o,
  output logic [31:0] perf_loaduse_o,
  output logic [31:0] perf_flush_o
`endif
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ABORT   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_WCNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_wcnt;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_wcnt_nxt;
  logic             w_memwait;
  logic             w_loaduse;
  logic             w_pc_stall;
  logic             w_ifid_stall;
  logic             w_pa;
  logic             w_wash_ifid;
  logic             w_wash_idex;
  logic             w_wash_exmem;
  logic             w_exc_redirect;
  logic             w_bus_err;

  assign w_memwait = mem_dmen_i & ~dmem_ready_i;
  assign w_loaduse = ex_memtoreg_i & ex_regwr_i & (ex_regdst_addr_i != 5'd0) &
                     ((id_uses_rs_i & (id_rs_addr_i == ex_regdst_addr_i)) |
                      (id_uses_rt_i & (id_rt_addr_i == ex_regdst_addr_i)));

  always_comb begin
    w_state_nxt    = r_state;
    w_wcnt_nxt     = r_wcnt;
    w_pc_stall     = 1'b0;
    w_ifid_stall   = 1'b0;
    w_pa           = 1'b0;
    w_wash_ifid    = 1'b0;
    w_wash_idex    = 1'b0;
    w_wash_exmem   = 1'b0;
    w_exc_redirect = 1'b0;
    w_bus_err      = 1'b0;
    case (r_state)
      RUN: begin
        if (w_memwait) begin
          w_pc_stall   = 1'b1;
          w_ifid_stall = 1'b1;
          w_pa         = 1'b1;
          w_state_nxt  = MEMWAIT;
          w_wcnt_nxt   = CNT_W'(1);
        end else if (mem_exc_req_i) begin
          w_wash_ifid    = 1'b1;
          w_wash_idex    = 1'b1;
          w_wash_exmem   = 1'b1;
          w_exc_redirect = 1'b1;
        end else if (ex_br_taken_i) begin
          // Delay slot already in ID is allowed to proceed.
          w_wash_ifid = 1'b1;
        end else if (w_loaduse) begin
          w_pc_stall   = 1'b1;
          w_ifid_stall = 1'b1;
          w_wash_idex  = 1'b1;
        end
      end
      MEMWAIT: begin
        if (dmem_ready_i) begin
          w_state_nxt = RUN;
          w_wcnt_nxt  = '0;
        end else begin
          w_pc_stall   = 1'b1;
          w_ifid_stall = 1'b1;
          w_pa         = 1'b1;
          if (r_wcnt == LP_WCNT_LAST) begin
            w_state_nxt = ABORT;
          end else begin
            w_wcnt_nxt = r_wcnt + CNT_W'(1);
          end
        end
      end
      ABORT: begin
        w_bus_err      = 1'b1;
        w_wash_ifid    = 1'b1;
        w_wash_idex    = 1'b1;
        w_wash_exmem   = 1'b1;
        w_exc_redirect = 1'b1;
        w_state_nxt    = RUN;
        w_wcnt_nxt     = '0;
      end
      default: begin
        w_state_nxt = RUN;
        w_wcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  // Reset is asynchronous, so it also masks the combinational outputs directly.
  assign pc_stall_o     = w_pc_stall     & reset;
  assign ifid_stall_o   = w_ifid_stall   & reset;
  assign pa_idexmemwr_o = w_pa           & reset;
  assign wash_ifid_o    = w_wash_ifid    & reset;
  assign wash_idex_o    = w_wash_idex    & reset;
  assign wash_exmem_o   = w_wash_exmem   & reset;
  assign exc_redirect_o = w_exc_redirect & reset;
  assign bus_err_o      = w_bus_err      & reset;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_perf_memwait;
  logic [31:0] r_perf_loaduse;
  logic [31:0] r_perf_flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_memwait <= '0;
      r_perf_loaduse <= '0;
      r_perf_flush   <= '0;
    end else if (perf_clr_i) begin
      r_perf_memwait <= '0;
      r_perf_loaduse <= '0;
      r_perf_flush   <= '0;
    end else begin
      if (pa_idexmemwr_o) r_perf_memwait <= r_perf_memwait + 32'd1;
      // Only the load-use bubble stalls PC and washes ID/EX together.
      if (pc_stall_o & wash_idex_o) r_perf_loaduse <= r_perf_loaduse + 32'd1;
      if (wash_ifid_o) r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign perf_memwait_o = r_perf_memwait;
  assign perf_loaduse_o = r_perf_loaduse;
  assign perf_flush_o   = r_perf_flush;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed plan cases then randomized traffic vs. a cycle model.
module tb_pipe_hazard_ctrl;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs_addr_i, id_rt_addr_i, ex_regdst_addr_i;
  logic       id_uses_rs_i, id_uses_rt_i, ex_regwr_i, ex_memtoreg_i;
  logic       ex_br_taken_i, mem_dmen_i, dmem_ready_i, mem_exc_req_i;
  logic       pc_stall_o, ifid_stall_o, pa_idexmemwr_o, wash_ifid_o;
  logic       wash_idex_o, wash_exmem_o, exc_redirect_o, bus_err_o;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i),
    .id_uses_rs_i(id_uses_rs_i), .id_uses_rt_i(id_uses_rt_i),
    .ex_regwr_i(ex_regwr_i), .ex_memtoreg_i(ex_memtoreg_i),
    .ex_regdst_addr_i(ex_regdst_addr_i), .ex_br_taken_i(ex_br_taken_i),
    .mem_dmen_i(mem_dmen_i), .dmem_ready_i(dmem_ready_i), .mem_exc_req_i(mem_exc_req_i),
    .pc_stall_o(pc_stall_o), .ifid_stall_o(ifid_stall_o), .pa_idexmemwr_o(pa_idexmemwr_o),
    .wash_ifid_o(wash_ifid_o), .wash_idex_o(wash_idex_o), .wash_exmem_o(wash_exmem_o),
    .exc_redirect_o(exc_redirect_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       dmen, rdy, exc, br, ldm, rw, urs, urt;
    logic [4:0] dst, rs, rt;
  } stim_t;

  typedef struct {
    logic [7:0] exp;
    int         cyc;
  } sb_t;

  // Expected output bit order: {pc, ifid, pa, wash_ifid, wash_idex, wash_exmem, exc_redirect, bus_err}
  localparam logic [7:0] E_IDLE  = 8'b000_00000;
  localparam logic [7:0] E_STALL = 8'b111_00000;
  localparam logic [7:0] E_EXC   = 8'b000_11110;
  localparam logic [7:0] E_BR    = 8'b000_10000;
  localparam logic [7:0] E_LU    = 8'b110_01000;
  localparam logic [7:0] E_ABORT = 8'b000_11111;

  sb_t sb_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc   = 0;

  // Model: count of stalled cycles in the current memory wait, and a pending abort cycle.
  int  m_stalls = 0;
  bit  m_abort  = 1'b0;

  function automatic stim_t idle();
    stim_t s;
    s.rst_n = 1'b1; s.dmen = 1'b0; s.rdy = 1'b0; s.exc = 1'b0; s.br = 1'b0;
    s.ldm = 1'b0; s.rw = 1'b0; s.urs = 1'b0; s.urt = 1'b0;
    s.dst = 5'd0; s.rs = 5'd0; s.rt = 5'd0;
    return s;
  endfunction

  function automatic stim_t lu_stim(input logic [4:0] d);
    stim_t s = idle();
    s.ldm = 1'b1; s.rw = 1'b1; s.dst = d; s.rs = 5'd5; s.urs = 1'b1;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.rst_n = ($urandom_range(0, 149) != 0);
    s.dmen  = ($urandom_range(0, 3) == 0);
    s.rdy   = ($urandom_range(0, 2) == 0);
    s.exc   = ($urandom_range(0, 5) == 0);
    s.br    = ($urandom_range(0, 3) == 0);
    s.ldm   = 1'($urandom_range(0, 1));
    s.rw    = 1'($urandom_range(0, 1));
    s.urs   = 1'($urandom_range(0, 1));
    s.urt   = 1'($urandom_range(0, 1));
    s.dst   = 5'($urandom_range(0, 3));
    s.rs    = 5'($urandom_range(0, 3));
    s.rt    = 5'($urandom_range(0, 3));
    return s;
  endfunction

  task automatic model(input stim_t s, output logic [7:0] e);
    logic lu;
    lu = s.ldm && s.rw && (s.dst != 0) &&
         ((s.urs && s.rs == s.dst) || (s.urt && s.rt == s.dst));
    if (!s.rst_n) begin
      e = E_IDLE; m_stalls = 0; m_abort = 1'b0;
    end else if (m_abort) begin
      e = E_ABORT; m_abort = 1'b0;
    end else if (m_stalls > 0) begin
      if (s.rdy) begin
        e = E_IDLE; m_stalls = 0;
      end else begin
        e = E_STALL; m_stalls++;
        if (m_stalls == T) begin m_abort = 1'b1; m_stalls = 0; end
      end
    end else if (s.dmen && !s.rdy) begin
      e = E_STALL; m_stalls = 1;
    end else if (s.exc) e = E_EXC;
    else if (s.br)      e = E_BR;
    else if (lu)        e = E_LU;
    else                e = E_IDLE;
  endtask

  task automatic drive(input stim_t s);
    sb_t item;
    @(posedge clk);
    #1;
    reset = s.rst_n; mem_dmen_i = s.dmen; dmem_ready_i = s.rdy; mem_exc_req_i = s.exc;
    ex_br_taken_i = s.br; ex_memtoreg_i = s.ldm; ex_regwr_i = s.rw; ex_regdst_addr_i = s.dst;
    id_rs_addr_i = s.rs; id_rt_addr_i = s.rt; id_uses_rs_i = s.urs; id_uses_rt_i = s.urt;
    cyc++;
    model(s, item.exp);
    item.cyc = cyc;
    sb_q.push_back(item);
  endtask

  initial begin : monitor
    sb_t        item;
    logic [7:0] got;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        item = sb_q.pop_front();
        got = {pc_stall_o, ifid_stall_o, pa_idexmemwr_o, wash_ifid_o,
               wash_idex_o, wash_exmem_o, exc_redirect_o, bus_err_o};
        n_cmp++;
        if (got !== item.exp) begin
          n_err++;
          $display("FAIL outs cyc=%0d got=%b exp=%b", item.cyc, got, item.exp);
        end
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    reset = 1'b0;
    {id_rs_addr_i, id_rt_addr_i, ex_regdst_addr_i} = '0;
    {id_uses_rs_i, id_uses_rt_i, ex_regwr_i, ex_memtoreg_i} = '0;
    {ex_br_taken_i, mem_dmen_i, dmem_ready_i, mem_exc_req_i} = '0;

    // Reset held: outputs zero regardless of inputs.
    for (int i = 0; i < 3; i++) begin s = rnd(); s.rst_n = 1'b0; s.exc = 1'b1; drive(s); end
    drive(idle());

    // Load-use bubble, then same stimulus with r0 destination.
    drive(lu_stim(5'd5)); drive(idle());
    drive(lu_stim(5'd0)); drive(idle());

    // Memory wait: 3 low cycles then ready.
    s = idle(); s.dmen = 1'b1;
    for (int i = 0; i < 3; i++) drive(s);
    s.rdy = 1'b1; drive(s); drive(idle());

    // Timeout: T stalls then the abort cycle.
    s = idle(); s.dmen = 1'b1;
    for (int i = 0; i < T; i++) drive(s);
    drive(idle()); drive(idle());

    // Priority: exception beats branch and load-use in RUN; all ignored in MEMWAIT.
    s = lu_stim(5'd5); s.exc = 1'b1; s.br = 1'b1; drive(s);
    s = idle(); s.dmen = 1'b1; drive(s);
    s = lu_stim(5'd5); s.exc = 1'b1; s.br = 1'b1; s.dmen = 1'b1; drive(s);
    s.rdy = 1'b1; s.exc = 1'b0; s.br = 1'b0; s.ldm = 1'b0; drive(s);

    // Branch masks load-use.
    s = lu_stim(5'd5); s.br = 1'b1; drive(s); drive(idle());

    // Reset in the 2nd MEMWAIT cycle, then a full-length timeout afterwards.
    s = idle(); s.dmen = 1'b1;
    drive(s); drive(s);
    s.rst_n = 1'b0; drive(s);
    s.rst_n = 1'b1;
    for (int i = 0; i < T + 1; i++) drive(s);
    drive(idle());

    for (int i = 0; i < 3000; i++) drive(rnd());

    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain left=%0d expected=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
